// File: rtl/am_pkg.sv
// rtl/am_pkg.sv - shared types and constants for the burst memory slave
package am_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WR_BURST = 2'd1,
        RD_BURST = 2'd2
    } state_t;

    localparam int DATA_WIDTH_DEF = 64;
    localparam int BYTES          = DATA_WIDTH_DEF / 8;

    // Number of low byte-address bits that select a byte inside one data word.
    function automatic int word_shift(input int data_width);
        return $clog2(data_width / 8);
    endfunction

endpackage

// File: rtl/am_be_ram.sv
// rtl/am_be_ram.sv - single-port RAM with per-byte write enable and registered read
module am_be_ram #(
    parameter int DATA_WIDTH     = 64,
    parameter int MEM_DEPTH_LOG2 = 10
) (
    input  logic                      clk_i,
    input  logic                      we_i,
    input  logic                      re_i,
    input  logic [MEM_DEPTH_LOG2-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0]     wdata_i,
    input  logic [DATA_WIDTH/8-1:0]   be_i,
    output logic [DATA_WIDTH-1:0]     rdata_o
);

    localparam int NBYTES = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] mem_q [2**MEM_DEPTH_LOG2];
    logic [DATA_WIDTH-1:0] rdata_q;

    // The read register only loads on re_i so the last word stays on the bus.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int b = 0; b < NBYTES; b++) begin
                if (be_i[b]) begin
                    mem_q[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
                end
            end
        end
        if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/am_burst_mem_slave.sv
// rtl/am_burst_mem_slave.sv - Avalon-MM pipelined burst slave over byte-enabled RAM
module am_burst_mem_slave
    import am_pkg::*;
#(
    parameter int DATA_WIDTH     = 64,
    parameter int ADDR_WIDTH     = 32,
    parameter int BURST_WIDTH    = 8,
    parameter int MEM_DEPTH_LOG2 = 10
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [ADDR_WIDTH-1:0]   slv_address,
    input  logic [BURST_WIDTH-1:0]  slv_burstcount,
    input  logic                    slv_write,
    input  logic [DATA_WIDTH-1:0]   slv_writedata,
    input  logic [DATA_WIDTH/8-1:0] slv_byteenable,
    input  logic                    slv_read,
    output logic                    slv_waitrequest,
    output logic [DATA_WIDTH-1:0]   slv_readdata,
    output logic                    slv_readdata_valid,
    output logic                    protocol_err_o
);

    localparam int SHIFT = word_shift(DATA_WIDTH);

    typedef logic [MEM_DEPTH_LOG2-1:0] idx_t;
    typedef logic [BURST_WIDTH-1:0]    cnt_t;

    state_t state_q, state_d;
    idx_t   addr_q, addr_d;
    cnt_t   cnt_q, cnt_d;
    logic   valid_q;
    logic   seen_q;
    logic   err_q, err_d;

    idx_t   cmd_idx;
    cnt_t   cmd_cnt;
    logic   cmd_zero;

    logic                  ram_we;
    logic                  ram_re;
    idx_t                  ram_addr;
    logic [DATA_WIDTH-1:0] ram_rdata;

    logic unused_addr_bits;
    assign unused_addr_bits = ^slv_address;

    assign cmd_idx  = slv_address[SHIFT +: MEM_DEPTH_LOG2];
    assign cmd_zero = (slv_burstcount == '0);
    assign cmd_cnt  = cmd_zero ? BURST_WIDTH'(1) : slv_burstcount;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            seen_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            valid_q <= ram_re;
            seen_q  <= seen_q | ram_re;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (slv_write) begin
                    addr_d = cmd_idx + MEM_DEPTH_LOG2'(1);
                    cnt_d  = cmd_cnt - BURST_WIDTH'(1);
                    if (cmd_cnt != BURST_WIDTH'(1)) state_d = WR_BURST;
                    if (slv_read || cmd_zero) err_d = 1'b1;
                end else if (slv_read) begin
                    addr_d  = cmd_idx;
                    cnt_d   = cmd_cnt;
                    state_d = RD_BURST;
                    if (cmd_zero) err_d = 1'b1;
                end
            end
            WR_BURST: begin
                if (slv_read) err_d = 1'b1;
                if (slv_write) begin
                    addr_d = addr_q + MEM_DEPTH_LOG2'(1);
                    cnt_d  = cnt_q - BURST_WIDTH'(1);
                    if (cnt_q == BURST_WIDTH'(1)) state_d = IDLE;
                end
            end
            RD_BURST: begin
                addr_d = addr_q + MEM_DEPTH_LOG2'(1);
                cnt_d  = cnt_q - BURST_WIDTH'(1);
                if (cnt_q == BURST_WIDTH'(1)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Write wins over a simultaneous read, so the RAM never sees both strobes.
    always_comb begin
        ram_we          = 1'b0;
        ram_re          = 1'b0;
        ram_addr        = addr_q;
        slv_waitrequest = rst_i || (state_q == RD_BURST);
        case (state_q)
            IDLE: begin
                if (slv_write) begin
                    ram_we   = 1'b1;
                    ram_addr = cmd_idx;
                end
            end
            WR_BURST: ram_we = slv_write;
            RD_BURST: ram_re = 1'b1;
            default: ;
        endcase
    end

    am_be_ram #(
        .DATA_WIDTH    (DATA_WIDTH),
        .MEM_DEPTH_LOG2(MEM_DEPTH_LOG2)
    ) u_ram (
        .clk_i  (clk_i),
        .we_i   (ram_we),
        .re_i   (ram_re),
        .addr_i (ram_addr),
        .wdata_i(slv_writedata),
        .be_i   (slv_byteenable),
        .rdata_o(ram_rdata)
    );

    assign slv_readdata       = seen_q ? ram_rdata : '0;
    assign slv_readdata_valid = valid_q;
    assign protocol_err_o     = err_q;

endmodule

// File: tb/tb_am_burst_mem_slave.sv
// tb/tb_am_burst_mem_slave.sv - directed self-checking bench for am_burst_mem_slave
module tb_am_burst_mem_slave;

    logic        clk_i;
    logic        rst_i;
    logic [31:0] slv_address;
    logic [7:0]  slv_burstcount;
    logic        slv_write;
    logic [63:0] slv_writedata;
    logic [7:0]  slv_byteenable;
    logic        slv_read;
    logic        slv_waitrequest;
    logic [63:0] slv_readdata;
    logic        slv_readdata_valid;
    logic        protocol_err_o;

    int checks = 0;
    int fails  = 0;
    logic [63:0] exp_data [16];

    am_burst_mem_slave #(
        .DATA_WIDTH(64), .ADDR_WIDTH(32), .BURST_WIDTH(8), .MEM_DEPTH_LOG2(10)
    ) dut (
        .clk_i             (clk_i),
        .rst_i             (rst_i),
        .slv_address       (slv_address),
        .slv_burstcount    (slv_burstcount),
        .slv_write         (slv_write),
        .slv_writedata     (slv_writedata),
        .slv_byteenable    (slv_byteenable),
        .slv_read          (slv_read),
        .slv_waitrequest   (slv_waitrequest),
        .slv_readdata      (slv_readdata),
        .slv_readdata_valid(slv_readdata_valid),
        .protocol_err_o    (protocol_err_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic wr_cmd(input logic [31:0] addr, input logic [7:0] bc,
                          input logic [63:0] data, input logic [7:0] be);
        slv_address = addr; slv_burstcount = bc;
        slv_writedata = data; slv_byteenable = be; slv_write = 1'b1;
        tick();
        slv_write = 1'b0;
    endtask

    task automatic wr_beat(input logic [63:0] data, input logic [7:0] be);
        slv_writedata = data; slv_byteenable = be; slv_write = 1'b1;
        tick();
        slv_write = 1'b0;
    endtask

    // Issues a read in cycle T; expects beats exp_data[0..n-1] in T+2..T+n+1.
    task automatic read_check(input string name, input logic [31:0] addr, input int n);
        slv_address = addr; slv_burstcount = n[7:0]; slv_read = 1'b1;
        tick();
        slv_read = 1'b0;
        checks++;
        if (slv_readdata_valid !== 1'b0) begin
            fails++; $display("FAIL %s early_valid: got %b want 0", name, slv_readdata_valid);
        end
        for (int i = 0; i < n; i++) begin
            tick();
            checks++;
            if (slv_readdata_valid !== 1'b1 || slv_readdata !== exp_data[i]) begin
                fails++;
                $display("FAIL %s beat%0d: got v=%b d=%h want v=1 d=%h",
                         name, i, slv_readdata_valid, slv_readdata, exp_data[i]);
            end
        end
        tick();
        checks++;
        if (slv_readdata_valid !== 1'b0) begin
            fails++; $display("FAIL %s late_valid: got %b want 0", name, slv_readdata_valid);
        end
    endtask

    task automatic test_reset();
        tick(); tick();
        checks++;
        if (slv_waitrequest !== 1'b1 || slv_readdata_valid !== 1'b0 ||
            slv_readdata !== 64'h0 || protocol_err_o !== 1'b0) begin
            fails++;
            $display("FAIL reset_outputs: got wr=%b v=%b d=%h err=%b want 1 0 0 0",
                     slv_waitrequest, slv_readdata_valid, slv_readdata, protocol_err_o);
        end
        rst_i = 1'b0;
        tick();
        checks++;
        if (slv_waitrequest !== 1'b0) begin
            fails++; $display("FAIL reset_release_wait: got %b want 0", slv_waitrequest);
        end
    endtask

    task automatic test_single();
        wr_cmd(32'h10, 8'd1, 64'h1122334455667788, 8'hFF);
        slv_address = 32'h10; slv_burstcount = 8'd1; slv_read = 1'b1;
        checks++;
        if (slv_waitrequest !== 1'b0) begin
            fails++; $display("FAIL single_wait_T: got %b want 0", slv_waitrequest);
        end
        tick();
        slv_read = 1'b0;
        checks++;
        if (slv_waitrequest !== 1'b1 || slv_readdata_valid !== 1'b0) begin
            fails++; $display("FAIL single_T1: got wr=%b v=%b want 1 0", slv_waitrequest, slv_readdata_valid);
        end
        tick();
        checks++;
        if (slv_waitrequest !== 1'b0 || slv_readdata_valid !== 1'b1 ||
            slv_readdata !== 64'h1122334455667788) begin
            fails++;
            $display("FAIL single_T2: got wr=%b v=%b d=%h want 0 1 1122334455667788",
                     slv_waitrequest, slv_readdata_valid, slv_readdata);
        end
        tick();
        checks++;
        if (slv_readdata_valid !== 1'b0 || slv_readdata !== 64'h1122334455667788) begin
            fails++;
            $display("FAIL single_T3_hold: got v=%b d=%h want 0 1122334455667788",
                     slv_readdata_valid, slv_readdata);
        end
    endtask

    task automatic test_partial();
        wr_cmd(32'h10, 8'd1, 64'hAAAAAAAAAAAAAAAA, 8'h0F);
        exp_data[0] = 64'h11223344AAAAAAAA;
        read_check("partial", 32'h10, 1);
    endtask

    task automatic test_wrap();
        wr_cmd(32'h1FF0, 8'd4, 64'd1, 8'hFF);
        wr_beat(64'd2, 8'hFF);
        tick();
        wr_beat(64'd3, 8'hFF);
        wr_beat(64'd4, 8'hFF);
        for (int i = 0; i < 4; i++) exp_data[i] = 64'(i + 1);
        read_check("wrap_burst", 32'h1FF0, 4);
        exp_data[0] = 64'd3;
        read_check("wrap_word0", 32'h0, 1);
        exp_data[0] = 64'd4;
        read_check("wrap_word1", 32'h8, 1);
    endtask

    task automatic test_back_to_back();
        logic [63:0] got [$];
        wr_cmd(32'd800, 8'd16, 64'hB000, 8'hFF);
        for (int i = 1; i < 16; i++) wr_beat(64'hB000 + 64'(i), 8'hFF);
        slv_address = 32'd800; slv_burstcount = 8'd8; slv_read = 1'b1;
        tick();
        slv_read = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            if (slv_readdata_valid === 1'b1) got.push_back(slv_readdata);
            if (c == 9) begin
                checks++;
                if (slv_waitrequest !== 1'b0 || slv_readdata_valid !== 1'b1) begin
                    fails++;
                    $display("FAIL b2b_second_accept: got wr=%b v=%b want 0 1",
                             slv_waitrequest, slv_readdata_valid);
                end
                slv_address = 32'd864; slv_burstcount = 8'd8; slv_read = 1'b1;
            end
            tick();
            if (c == 9) slv_read = 1'b0;
        end
        checks++;
        if (got.size() != 16) begin
            fails++; $display("FAIL b2b_count: got %0d want 16", got.size());
        end
        for (int i = 0; i < 16 && i < got.size(); i++) begin
            checks++;
            if (got[i] !== 64'hB000 + 64'(i)) begin
                fails++; $display("FAIL b2b_beat%0d: got %h want %h", i, got[i], 64'hB000 + 64'(i));
            end
        end
    endtask

    task automatic test_rw_conflict();
        checks++;
        if (protocol_err_o !== 1'b0) begin
            fails++; $display("FAIL conflict_pre_err: got %b want 0", protocol_err_o);
        end
        slv_read = 1'b1;
        wr_cmd(32'h640, 8'd1, 64'hDEADBEEFCAFEF00D, 8'hFF);
        slv_read = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (slv_readdata_valid !== 1'b0) begin
                fails++; $display("FAIL conflict_no_valid%0d: got %b want 0", i, slv_readdata_valid);
            end
            tick();
        end
        checks++;
        if (protocol_err_o !== 1'b1) begin
            fails++; $display("FAIL conflict_err: got %b want 1", protocol_err_o);
        end
        exp_data[0] = 64'hDEADBEEFCAFEF00D;
        read_check("conflict_data", 32'h640, 1);
        checks++;
        if (protocol_err_o !== 1'b1) begin
            fails++; $display("FAIL conflict_err_sticky: got %b want 1", protocol_err_o);
        end
    endtask

    task automatic test_reset_mid();
        slv_address = 32'd800; slv_burstcount = 8'd8; slv_read = 1'b1;
        tick();
        slv_read = 1'b0;
        tick(); tick(); tick();
        checks++;
        if (slv_readdata_valid !== 1'b1 || slv_readdata !== 64'hB002) begin
            fails++; $display("FAIL rstmid_beat3: got v=%b d=%h want 1 b002", slv_readdata_valid, slv_readdata);
        end
        rst_i = 1'b1;
        #1;
        checks++;
        if (slv_readdata_valid !== 1'b0 || slv_waitrequest !== 1'b1 || protocol_err_o !== 1'b0) begin
            fails++;
            $display("FAIL rstmid_async: got v=%b wr=%b err=%b want 0 1 0",
                     slv_readdata_valid, slv_waitrequest, protocol_err_o);
        end
        tick();
        rst_i = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (slv_readdata_valid !== 1'b0 || slv_waitrequest !== 1'b0) begin
                fails++;
                $display("FAIL rstmid_after%0d: got v=%b wr=%b want 0 0", i, slv_readdata_valid, slv_waitrequest);
            end
            tick();
        end
        exp_data[0] = 64'hB005;
        read_check("rstmid_read", 32'd840, 1);
    endtask

    task automatic test_zero_burst();
        wr_cmd(32'h960, 8'd0, 64'h0123456789ABCDEF, 8'hFF);
        checks++;
        if (protocol_err_o !== 1'b1) begin
            fails++; $display("FAIL zero_burst_err: got %b want 1", protocol_err_o);
        end
        exp_data[0] = 64'h0123456789ABCDEF;
        read_check("zero_burst_read", 32'h960, 1);
    endtask

    initial begin
        rst_i = 1'b1;
        slv_address = '0; slv_burstcount = '0; slv_write = 1'b0;
        slv_writedata = '0; slv_byteenable = '0; slv_read = 1'b0;
        test_reset();
        test_single();
        test_partial();
        test_wrap();
        test_back_to_back();
        test_rw_conflict();
        test_reset_mid();
        test_zero_burst();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/am_burst_mem_slave.md
Name: am_burst_mem_slave

Overview:
- Avalon-MM pipelined burst responder backed by on-chip RAM with byte enables.
- It is the memory end that the byte-reordering master-side bridges talk to.
- It holds pattern/state tables written by the host and read back in bursts by the matcher.
- It accepts write bursts beat-by-beat and serves read bursts as back-to-back readdatavalid beats.

Parameters:
- DATA_WIDTH, 64, data bus width in bits; must be a multiple of 8.
- ADDR_WIDTH, 32, byte address width.
- BURST_WIDTH, 8, burstcount width; maximum burst is 2**BURST_WIDTH-1.
- MEM_DEPTH_LOG2, 10, log2 of RAM depth in DATA_WIDTH words.

Ports:
- clk_i  in  1  single clock; all logic is on the rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- slv_address  in  ADDR_WIDTH  byte address; sampled on the first beat only.
- slv_burstcount  in  BURST_WIDTH  beats in the burst; sampled on the first beat only.
- slv_write  in  1  write request.
- slv_writedata  in  DATA_WIDTH  write data.
- slv_byteenable  in  DATA_WIDTH/8  per-byte write enable.
- slv_read  in  1  read request.
- slv_waitrequest  out  1  stall; a beat or command is accepted when request=1 and waitrequest=0.
- slv_readdata  out  DATA_WIDTH  read data.
- slv_readdata_valid  out  1  marks valid read data.
- protocol_err_o  out  1  sticky protocol-violation flag; cleared only by rst_i.

Behaviour:
- Reset values while rst_i=1:
  - slv_waitrequest=1, slv_readdata_valid=0, slv_readdata=0, protocol_err_o=0, state=IDLE.
  - RAM contents are not cleared.
- Word index = slv_address[ADDR_WIDTH-1:log2(DATA_WIDTH/8)] modulo 2**MEM_DEPTH_LOG2. Low address bits are ignored.
- Burst addresses increment by one word per beat and wrap from the top word to word 0.
- burstcount=0 is treated as 1 and also sets protocol_err_o.
- State IDLE: waitrequest=0.
  - Accepted write: write beat 0 immediately, latch base index and count.
    - count=1: stay in IDLE.
    - otherwise: go to WR_BURST with remaining=count-1.
  - Accepted read: latch base index and count, go to RD_BURST.
  - read and write both asserted: write is accepted, read is dropped, protocol_err_o is set.
- State WR_BURST: waitrequest=0.
  - Each cycle with slv_write=1 writes the next word, applying byteenable per byte. Address and burstcount are ignored.
  - Cycles with slv_write=0 are idle beats; the counter holds.
  - After the last beat is accepted, return to IDLE next cycle.
  - slv_read=1 here sets protocol_err_o and is ignored.
- State RD_BURST: waitrequest=1, so no new commands are accepted.
  - RAM read latency is 1 cycle.
  - Command accepted in cycle T gives slv_readdata_valid=1 in cycles T+2 through T+1+N, one word per cycle, no gaps.
  - Return to IDLE in the cycle after the last RAM address is issued. The last valid beat still emerges one cycle later.
  - waitrequest=0 again in cycle T+N+1, so a new command can be accepted in the same cycle as the final readdata beat.
- slv_readdata holds its last value when valid=0. Only slv_readdata_valid qualifies the data.
- A write to word W followed immediately by a read of W returns the new data. A write always completes before any read is accepted.
- Reset asserted mid-burst: counters are cleared, remaining beats are discarded, slv_readdata_valid drops asynchronously, and the state returns to IDLE.
- Beat counter width is BURST_WIDTH. Address arithmetic is MEM_DEPTH_LOG2 bits and wraps naturally.

Decomposition:
- Package am_pkg holds:
  - the state enum (IDLE, WR_BURST, RD_BURST);
  - the BYTES = DATA_WIDTH/8 constant;
  - a function computing the word-offset shift, clog2(BYTES).
- Sub-module am_be_ram: single-port RAM, DATA_WIDTH x 2**MEM_DEPTH_LOG2, per-byte write enable, registered 1-cycle read, no reset on the array.
- The top level holds the FSM, counters, valid pipeline and error flag.

Test Plan:
- Single write, address 0x10, data 0x1122334455667788, byteenable 0xFF. Then read of address 0x10 with burstcount 1 → readdata_valid exactly 2 cycles after acceptance with 0x1122334455667788; waitrequest high for exactly 1 cycle.
- Partial write with byteenable 0x0F of 0xAAAAAAAAAAAAAAAA over 0x1122334455667788, then read → 0x11223344AAAAAAAA.
- 4-beat write burst at word 1022 (MEM_DEPTH_LOG2=10) with data 1,2,3,4, with one idle cycle inserted after beat 2. Then a 4-beat read at word 1022 → beats 1,2,3,4 on consecutive cycles; words 0 and 1 hold 3 and 4 (wrap).
- Back-to-back 8-beat reads → second command accepted in the cycle the first burst's last beat is returned; 16 valid beats total, no overlap or loss.
- slv_read and slv_write asserted together in IDLE → write performed, no readdata_valid, protocol_err_o=1 and stays 1 until rst_i.
- rst_i pulsed during beat 3 of an 8-beat read → readdata_valid=0 from reset onward, waitrequest=1 during reset then 0. A new 1-beat read then returns the correct data.
